// File: rtl/alu_add_pipe.sv
// alu_add_pipe: pipelined adder/subtractor with carry, overflow and zero flags.
// The WIDTH-bit add is split into STAGES segments of SEG bits. Carries move
// between segments through pipeline registers, so each stage ripples only SEG
// bits. The whole pipe advances together when the output slot is free or is
// being drained (valid/ready handshake with full backpressure).
module alu_add_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Stage k registers hold the operation after segment k has been summed.
  logic [STAGES-1:0]             vld_r;
  logic [STAGES-1:0][WIDTH-1:0]  a_r;
  logic [STAGES-1:0][WIDTH-1:0]  b_r;
  logic [STAGES-1:0][WIDTH-1:0]  s_r;
  logic [STAGES-1:0]             c_r;
  logic                          co_r;
  logic                          ovf_r;
  logic                          zero_r;

  // What each stage sees on its input side, and what it will register.
  logic [STAGES-1:0]             v_in_s;
  logic [STAGES-1:0]             cin_s;
  logic [STAGES-1:0][WIDTH-1:0]  a_in_s;
  logic [STAGES-1:0][WIDTH-1:0]  b_in_s;
  logic [STAGES-1:0][WIDTH-1:0]  s_in_s;
  logic [STAGES-1:0][WIDTH-1:0]  s_nx_s;
  logic [STAGES-1:0]             c_nx_s;
  logic [SEG:0]                  seg_s;

  logic adv_s;
  logic msb_cin_s;
  logic co_nx_s;
  logic ovf_nx_s;
  logic zero_nx_s;
  logic unused_s;

  // A free or draining output slot lets every stage shift; in_ready ignores in_valid.
  assign adv_s    = ~vld_r[LAST] | out_ready;
  assign in_ready = adv_s;

  // Route the ports into stage 0 and each stage register into the next stage.
  always_comb begin
    v_in_s = '0;
    cin_s  = '0;
    a_in_s = '0;
    b_in_s = '0;
    s_in_s = '0;
    v_in_s[0] = in_valid;
    a_in_s[0] = a;
    if (sub) begin
      b_in_s[0] = ~b;
    end else begin
      b_in_s[0] = b;
    end
    s_in_s[0] = '0;
    cin_s[0]  = ci;
    for (int k = 1; k < STAGES; k++) begin
      v_in_s[k] = vld_r[k-1];
      a_in_s[k] = a_r[k-1];
      b_in_s[k] = b_r[k-1];
      s_in_s[k] = s_r[k-1];
      cin_s[k]  = c_r[k-1];
    end
  end

  // Each stage adds its own SEG-bit slice and drops it into the partial sum.
  always_comb begin
    seg_s  = '0;
    s_nx_s = '0;
    c_nx_s = '0;
    for (int k = 0; k < STAGES; k++) begin
      seg_s = {1'b0, a_in_s[k][k*SEG +: SEG]}
            + {1'b0, b_in_s[k][k*SEG +: SEG]}
            + {{SEG{1'b0}}, cin_s[k]};
      s_nx_s[k]                = s_in_s[k];
      s_nx_s[k][k*SEG +: SEG]  = seg_s[SEG-1:0];
      c_nx_s[k]                = seg_s[SEG];
    end
  end

  // Flags come from the final segment: carry into the MSB is recovered from
  // the MSB sum bit, so no extra adder is needed.
  always_comb begin
    msb_cin_s = a_in_s[LAST][WIDTH-1] ^ b_in_s[LAST][WIDTH-1] ^ s_nx_s[LAST][WIDTH-1];
    co_nx_s   = c_nx_s[LAST];
    ovf_nx_s  = msb_cin_s ^ co_nx_s;
    zero_nx_s = (s_nx_s[LAST] == {WIDTH{1'b0}});
  end

  // Operand bits already consumed by earlier stages are left for synthesis to prune.
  assign unused_s = ^{a_r, b_r, c_r, a_in_s, b_in_s};

  // Pipeline registers: clear on reset, shift on advance, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_r  <= '0;
      a_r    <= '0;
      b_r    <= '0;
      s_r    <= '0;
      c_r    <= '0;
      co_r   <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else if (adv_s) begin
      vld_r  <= v_in_s;
      a_r    <= a_in_s;
      b_r    <= b_in_s;
      s_r    <= s_nx_s;
      c_r    <= c_nx_s;
      co_r   <= co_nx_s;
      ovf_r  <= ovf_nx_s;
      zero_r <= zero_nx_s;
    end
  end

  assign out_valid = vld_r[LAST];
  assign sum       = s_r[LAST];
  assign co        = co_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_alu_add_pipe.sv
// Self-checking bench for alu_add_pipe: directed vectors on a 32-bit/4-stage
// instance and an 8-bit/1-stage instance, with a scoreboard for ordering.
module tb_alu_add_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        ci, sub, co, ovf, zero;

  logic        v8, rdy8, ov8, ordy8, ci8, sub8, co8, ovf8, z8;
  logic [7:0]  a8, b8, sum8;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int first_drain, last_drain;
  logic [34:0] q[$];
  logic        stalled;
  logic [34:0] held;

  alu_add_pipe #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .co(co), .ovf(ovf), .zero(zero));

  alu_add_pipe #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8),
    .a(a8), .b(b8), .ci(ci8), .sub(sub8), .out_valid(ov8), .out_ready(ordy8),
    .sum(sum8), .co(co8), .ovf(ovf8), .zero(z8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent reference: full-width add, overflow from operand/result signs.
  function automatic logic [34:0] model(logic [31:0] x, logic [31:0] y, logic c, logic s);
    logic [31:0] be;
    logic [32:0] f;
    logic        o;
    be = s ? ~y : y;
    f  = {1'b0, x} + {1'b0, be} + {32'd0, c};
    o  = (x[31] == be[31]) && (f[31] != x[31]);
    return {f[32], o, (f[31:0] == 32'd0), f[31:0]};
  endfunction

  // One clock: account accepts/drains/stalls for the current inputs, then step.
  task automatic cycle(output logic acc);
    acc = 1'b0;
    #1;
    if (!reset && out_valid && !out_ready) begin
      check("in_ready_stall", {63'd0, in_ready}, 64'd0);
      if (stalled) check("held_outputs", {29'd0, co, ovf, zero, sum}, {29'd0, held});
      held    = {co, ovf, zero, sum};
      stalled = 1'b1;
    end else begin
      stalled = 1'b0;
    end
    if (!reset && out_valid && out_ready) begin
      check("sb_has_entry", {63'd0, q.size() != 0}, 64'd1);
      if (q.size() != 0) check("result", {29'd0, co, ovf, zero, sum}, {29'd0, q.pop_front()});
      if (first_drain < 0) first_drain = cyc;
      last_drain = cyc;
    end
    if (!reset && in_valid && in_ready) begin
      q.push_back(model(a, b, ci, sub));
      acc = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Issue one operation and compare against hand-computed results and latency.
  task automatic run_dir(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                         input logic xc, input logic xs, input logic [31:0] es,
                         input logic eco, input logic eov, input logic ez);
    logic acc;
    int   lat;
    in_valid = 1'b1; a = xa; b = xb; ci = xc; sub = xs; out_ready = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      cycle(acc);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_sum"}, {32'd0, sum}, {32'd0, es});
    check({tag, "_flags"}, {61'd0, co, ovf, zero}, {61'd0, eco, eov, ez});
    cycle(acc);
  endtask

  logic [31:0] sa[16], sb[16];
  logic        sc[16], ss[16];

  initial begin
    logic acc;
    int   issued, base, guard;
    first_drain = -1; last_drain = -1; stalled = 1'b0; held = '0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 32'd0; b = 32'd0; ci = 1'b0; sub = 1'b0;
    v8 = 1'b0; ordy8 = 1'b1; a8 = 8'd0; b8 = 8'd0; ci8 = 1'b0; sub8 = 1'b0;

    // Reset state
    cycle(acc);
    cycle(acc);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum", {32'd0, sum}, 64'd0);
    check("rst_flags", {61'd0, co, ovf, zero}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid8", {63'd0, ov8}, 64'd0);
    reset = 1'b0;

    // Directed vectors
    run_dir("carry_chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_dir("sub_ovf",     32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_dir("sub_borrow",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_dir("add_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_dir("add_ci",      32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0);
    run_dir("sub_equal",   32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // Degenerate 8-bit, single-stage instance
    v8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0; sub8 = 1'b0;
    @(posedge clk); #1;
    check("d8_valid", {63'd0, ov8}, 64'd1);
    check("d8_sum1", {56'd0, sum8}, 64'h80);
    check("d8_flags1", {61'd0, co8, ovf8, z8}, {61'd0, 3'b010});
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    @(posedge clk); #1;
    check("d8_sum2", {56'd0, sum8}, 64'hFF);
    check("d8_flags2", {61'd0, co8, ovf8, z8}, {61'd0, 3'b100});
    v8 = 1'b0;
    @(posedge clk); #1;
    check("d8_idle", {63'd0, ov8}, 64'd0);

    // Bubbles: 1,0,1,0 in -> same pattern out, STAGES cycles later
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 4) && (i % 2 == 0);
      a = 32'h100 * i; b = 32'd3 + i; ci = 1'b0; sub = 1'b0;
      check($sformatf("bubble_%0d", i), {63'd0, out_valid},
            {63'd0, (i >= 4 && i < 8 && (i % 2 == 0))});
      cycle(acc);
    end
    in_valid = 1'b0;

    // Streaming 16 ops with a 3-cycle stall mid-stream
    for (int i = 0; i < 16; i++) begin
      sa[i] = $urandom; sb[i] = $urandom; sc[i] = 1'($urandom_range(1)); ss[i] = 1'($urandom_range(1));
    end
    issued = 0; base = cyc; guard = 0; first_drain = -1; last_drain = -1;
    while ((issued < 16 || q.size() != 0) && guard < 100) begin
      out_ready = !((cyc - base) >= 6 && (cyc - base) <= 8);
      in_valid  = (issued < 16);
      if (issued < 16) begin
        a = sa[issued]; b = sb[issued]; ci = sc[issued]; sub = ss[issued];
      end
      cycle(acc);
      if (acc) issued++;
      guard++;
    end
    check("stream_done", 64'(guard < 100), 64'd1);
    check("stream_first", 64'(first_drain - base), 64'd4);
    check("stream_last", 64'(last_drain - base), 64'd22);
    in_valid = 1'b0; out_ready = 1'b1;

    // Reset mid-stream discards in-flight operations
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'hA0 + i; b = 32'h5; ci = 1'b0; sub = 1'b0;
      cycle(acc);
    end
    reset = 1'b1; a = 32'hFFFF; cycle(acc);
    reset = 1'b0; in_valid = 1'b0;
    q.delete();
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_sum", {32'd0, sum}, 64'd0);
    check("mid_rst_flags", {61'd0, co, ovf, zero}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("mid_rst_quiet_%0d", i), {63'd0, out_valid}, 64'd0);
      cycle(acc);
    end
    check("sb_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_add_pipe.md
# alu_add_pipe

Parametrised, pipelined adder/subtractor for the ALU datapath, replacing the single-cycle fixed 8-bit adder in wider and faster ALU builds. It splits a WIDTH-bit add into STAGES equal segments and carries between segments through pipeline registers, so each stage contains only a WIDTH/STAGES-bit ripple. It accepts one operation per cycle under a valid/ready handshake with full backpressure. Along with the result it returns carry-out, signed overflow and zero flags.

## Interface
- WIDTH, 32: operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4: number of pipeline segments; 1 ≤ STAGES ≤ WIDTH; latency equals STAGES.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block accepts the operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in.
- sub  in  1  0: a+b+ci; 1: a+~b+ci (ci=1 gives a−b).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- co  out  1  carry-out of the MSB; for subtract, co=1 means no borrow.
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  sum == 0.

## Operation
- Segment width is SEG = WIDTH/STAGES. Stage k (0-based) adds bits [k·SEG+SEG−1 : k·SEG] of a and b_eff, where b_eff = sub ? ~b : b.
- Stage 0 uses ci as its carry-in. Stage k>0 uses the registered carry from stage k−1.
- Not-yet-summed operand slices travel with the operation in per-stage skew registers. Finished sum slices are registered alongside. Each stage has a valid bit.
- Global advance: `adv = !out_valid | out_ready`. When adv=1, all stages shift one position and stage 0 loads the input; in_valid=0 loads a bubble (valid=0). When adv=0, all stage registers hold.
- in_ready = adv. It is combinational from out_valid and out_ready and does not depend on in_valid.
- Flags are computed in the final stage:
  - co = carry out of bit WIDTH−1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (sum == 0), reduced across all registered slices.
- Flags and sum are registered, so they change only on an accepted shift.
- STAGES=1 is a registered full-width adder with 1-cycle latency.
- Outputs hold stable while out_valid=1 and out_ready=0.

## Timing
- Reset, synchronous with reset=1 at a rising edge:
  - All stage valid bits go to 0, so out_valid=0.
  - sum=0, co=0, ovf=0, zero=0.
  - in_ready=1 in the cycle after reset, because out_valid=0.
- Reset dominates everything. Operations in flight are discarded, and an in_valid presented in the same cycle as reset is not accepted.
- Latency: an operation accepted at edge N (in_valid & in_ready) appears with out_valid=1 after edge N+STAGES−1, i.e. visible in cycle N+STAGES when there are no stalls.
- Throughput is 1 operation per cycle with out_ready held at 1. Back-to-back results are in issue order with no gaps.
- Stall: out_valid=1 & out_ready=0 freezes the whole pipe, including bubbles. in_ready=0 in that same cycle.
- Simultaneous accept and drain (out_valid & out_ready & in_valid) shifts in one cycle with no bubble inserted.
- Wrap-around: sum is modulo 2^WIDTH. Example: 0xFFFFFFFF + 1 gives sum=0, co=1, zero=1, ovf=0.
- No combinational path from a, b, ci or sub to any output.

## Test plan
- Reset mid-stream, WIDTH=32, STAGES=4: issue 3 operations, assert reset for 1 cycle → out_valid=0, sum=0, flags 0; none of the 3 results ever appear.
- Carry chain across all segments: a=0xFFFFFFFF, b=0x00000001, ci=0, sub=0 → after 4 cycles sum=0x00000000, co=1, zero=1, ovf=0. The carry must ripple through every stage boundary.
- Subtract and signed overflow: a=0x80000000, b=0x00000001, ci=1, sub=1 → sum=0x7FFFFFFF, co=1, ovf=1, zero=0. Then a=5, b=7, ci=1, sub=1 → sum=0xFFFFFFFE, co=0, ovf=0.
- Streaming with backpressure: 16 random operations back-to-back; drop out_ready for 3 cycles mid-stream → in_ready=0 during the stall, outputs held stable, all 16 results arrive in order and match a reference model. Zero throughput loss after out_ready returns.
- Degenerate configuration, WIDTH=8, STAGES=1: a=0x7F, b=0x01, ci=0 → next cycle sum=0x80, co=0, ovf=1. a=0xFF, b=0xFF, ci=1 → sum=0xFF, co=1.
- Bubbles: in_valid toggling 1,0,1,0 with out_ready=1 → out_valid reproduces the 1,0,1,0 pattern delayed by STAGES cycles, with no spurious valids.
